i2c_temp_slave: RTL

I2C responder (target) that emulates an LM75A-class temperature sensor on the FPGA's SCL/SDA pins. It answers read transactions addressed to its 7-bit device address and returns a 16-bit temperature word, MSB byte first. It runs from the system clock and oversamples the bus. It is the bench partner for the in-house I2C read initiator, and also serves as a sensor stand-in on boards without an LM75A.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_bus_sync.sv | 91 +++++++++
 rtl/i2c_temp_slave.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: constants shared by the I2C responder and the in-house initiator.
//   i2c_state_t         - responder FSM state encoding
//   DEFAULT_DEVICE_ADDR - 7-bit address answered by default (LM75A-class, 0x48)
//   I2C_READ / I2C_WRITE - R/W bit values in the address byte
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_TX_BYTE   = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_WAIT_STOP = 3'd5
    } i2c_state_t;

    localparam logic [6:0] DEFAULT_DEVICE_ADDR = 7'h48;
    localparam logic       I2C_READ            = 1'b1;
    localparam logic       I2C_WRITE           = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: brings SCL/SDA into the clk domain and derives bus events.
// Optional macro: I2C_SLAVE_GLITCH_FILTER_EN adds a 3-tap majority-free
// filter (level changes only when all taps agree) after the synchronizer.
// Ports:
//   clk, rst_n           - system clock, async active-low reset
//   scl, sda             - raw bus pins
//   scl_rise, scl_fall   - one-clk pulses on synchronized SCL edges
//   start_det, stop_det  - one-clk pulses on START / STOP conditions
//   sda_s                - synchronized (and filtered) SDA level
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       w_scl_lvl;
    logic       w_sda_lvl;

    // Reset to 1 so an idle bus produces no spurious events after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl};
            r_sda_sync <= {r_sda_sync[0], sda};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] r_scl_tap;
    logic [2:0] r_sda_tap;
    logic       r_scl_filt;
    logic       r_sda_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_tap  <= '1;
            r_sda_tap  <= '1;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_tap <= {r_scl_tap[1:0], r_scl_sync[1]};
            r_sda_tap <= {r_sda_tap[1:0], r_sda_sync[1]};
            if (r_scl_tap == 3'b111)
                r_scl_filt <= 1'b1;
            else if (r_scl_tap == 3'b000)
                r_scl_filt <= 1'b0;
            if (r_sda_tap == 3'b111)
                r_sda_filt <= 1'b1;
            else if (r_sda_tap == 3'b000)
                r_sda_filt <= 1'b0;
        end
    end

    assign w_scl_lvl = r_scl_filt;
    assign w_sda_lvl = r_sda_filt;
`else
    assign w_scl_lvl = r_scl_sync[1];
    assign w_sda_lvl = r_sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl_lvl;
            r_sda_prev <= w_sda_lvl;
        end
    end

    // START/STOP require SCL high in both samples so an SDA change that
    // coincides with an SCL edge is not mistaken for a bus condition.
    assign scl_rise  =  w_scl_lvl & ~r_scl_prev;
    assign scl_fall  = ~w_scl_lvl &  r_scl_prev;
    assign start_det =  w_scl_lvl &  r_scl_prev &  r_sda_prev & ~w_sda_lvl;
    assign stop_det  =  w_scl_lvl &  r_scl_prev & ~r_sda_prev &  w_sda_lvl;
    assign sda_s     =  w_sda_lvl;

endmodule

// File: rtl/i2c_temp_slave.sv
// i2c_temp_slave: I2C read-only responder emulating an LM75A-class sensor.
// Returns temp_data (high byte first, then alternating low/high) from a
// shadow copy latched at address match, so every byte of one transaction
// comes from the same sample.
// Optional macro: I2C_SLAVE_GLITCH_FILTER_EN (see i2c_bus_sync).
// Ports:
//   clk, rst_n  - system clock, async active-low reset
//   scl         - bus clock from the initiator
//   sda         - open-drain data; only driven low or released
//   temp_data   - temperature word to report
//   busy        - high from address match until STOP or START
//   read_done   - one-clk pulse when the initiator NACKs a data byte
module i2c_temp_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = DEFAULT_DEVICE_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    inout  logic        sda,
    input  logic [15:0] temp_data,
    output logic        busy,
    output logic        read_done
);

    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start_det;
    logic       w_stop_det;
    logic       w_sda_s;

    i2c_state_t  r_state;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [15:0] r_shadow;
    logic        r_byte_sel;   // 0: high byte next, 1: low byte next
    logic        r_ack_seen;
    logic        r_sda_oe;     // 1 drives SDA low
    logic        r_busy;
    logic        r_read_done;

    logic [7:0]  w_tx_byte;
    logic [2:0]  w_bit_idx;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start_det),
        .stop_det  (w_stop_det),
        .sda_s     (w_sda_s)
    );

    assign w_tx_byte = r_byte_sel ? r_shadow[7:0] : r_shadow[15:8];
    assign w_bit_idx = 3'd7 - r_bit_cnt[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_shadow    <= '0;
            r_byte_sel  <= 1'b0;
            r_ack_seen  <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_read_done <= 1'b0;
        end else begin
            r_read_done <= 1'b0;
            if (w_stop_det) begin
                r_state   <= ST_IDLE;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_bit_cnt <= '0;
            end else if (w_start_det) begin
                r_state   <= ST_ADDR;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_shift   <= {r_shift[6:0], w_sda_s};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= '0;
                            if (r_shift[7:1] == DEVICE_ADDR && r_shift[0] == I2C_READ) begin
                                r_state    <= ST_ADDR_ACK;
                                r_sda_oe   <= 1'b1;
                                r_shadow   <= temp_data;
                                r_byte_sel <= 1'b0;
                                r_busy     <= 1'b1;
                            end else begin
                                r_state  <= ST_WAIT_STOP;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= ~w_tx_byte[7];
                            r_bit_cnt <= 4'd1;
                            r_state   <= ST_TX_BYTE;
                        end
                    end
                    ST_TX_BYTE: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe   <= 1'b0;
                                r_bit_cnt  <= '0;
                                r_ack_seen <= 1'b0;
                                r_state    <= ST_RX_ACK;
                            end else begin
                                r_sda_oe  <= ~w_tx_byte[w_bit_idx];
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RX_ACK: begin
                        // ACK is sampled on the rising edge; the next byte's
                        // MSB goes out on the following falling edge.
                        if (w_scl_rise && !r_ack_seen) begin
                            if (w_sda_s) begin
                                r_read_done <= 1'b1;
                                r_state     <= ST_WAIT_STOP;
                            end else begin
                                r_ack_seen <= 1'b1;
                                r_byte_sel <= ~r_byte_sel;
                            end
                        end else if (w_scl_fall && r_ack_seen) begin
                            r_sda_oe   <= ~w_tx_byte[7];
                            r_bit_cnt  <= 4'd1;
                            r_ack_seen <= 1'b0;
                            r_state    <= ST_TX_BYTE;
                        end
                    end
                    ST_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda       = r_sda_oe ? 1'b0 : 1'bz;
    assign busy      = r_busy;
    assign read_done = r_read_done;

endmodule
